// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the SRAM slave.
//   - response codes, channel widths
//   - read-FSM state type
//   - addr_bad(): decides whether a byte address maps onto a storage word
package axil_pkg;

  localparam int AXIL_ADDR_W = 64;
  localparam int AXIL_DATA_W = 64;
  localparam int AXIL_STRB_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  // An address is rejected when it is not 8-byte aligned, lies below the
  // window base, or its word offset falls beyond the last storage word.
  function automatic logic addr_bad(input logic [AXIL_ADDR_W-1:0] addr,
                                    input logic [AXIL_ADDR_W-1:0] base,
                                    input logic [AXIL_ADDR_W-1:0] words);
    logic [AXIL_ADDR_W-1:0] off;
    off = addr - base;
    return (addr[2:0] != 3'd0) || (addr < base) || ((off >> 3) >= words);
  endfunction

endpackage

// File: rtl/axil_sram_array.sv
// Backing storage: WORDS x 64-bit, one byte-enabled write port and one
// synchronous read port. On a same-cycle read/write of one word the read
// returns the old contents. Contents are never reset.
// Ports:
//   clk              clock
//   i_we/i_waddr     write enable / word index
//   i_wdata/i_wstrb  write data / byte enables
//   i_re/i_raddr     read enable / word index
//   o_rdata          registered read data (holds until the next read)
module axil_sram_array
  import axil_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int IDX_W = 10
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_waddr,
  input  logic [AXIL_DATA_W-1:0] i_wdata,
  input  logic [AXIL_STRB_W-1:0] i_wstrb,
  input  logic                   i_re,
  input  logic [IDX_W-1:0]       i_raddr,
  output logic [AXIL_DATA_W-1:0] o_rdata
);

  logic [AXIL_DATA_W-1:0] r_mem [WORDS];
  logic [AXIL_DATA_W-1:0] r_rdata;

  // Both accesses sit in one block with non-blocking assignments, so the
  // read always picks up the value from before this edge's write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < AXIL_STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave in front of a 64-bit SRAM.
// Write side: AW and W are each captured in a holding register (in any
// order); the write commits in the cycle both are available and B is raised
// the next cycle. Read side: a three-state FSM (r_rstate) counts RD_LAT
// cycles from the AR transfer to rvalid_o.
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a raised valid and its payload stay put
// until that transfer.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   aw*/w*/b*                  write address / data / response channels
//   ar*/r*                     read address / data channels
//   awprot_i, arprot_i         accepted but unused
module axil_sram_slave
  import axil_pkg::*;
#(
  parameter int                     MEM_WORDS = 1024,
  parameter logic [AXIL_ADDR_W-1:0] BASE_ADDR = 64'h0,
  parameter int                     RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [AXIL_ADDR_W-1:0] awaddr_i,
  input  logic                   awprot_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  input  logic [AXIL_DATA_W-1:0] wdata_i,
  input  logic [AXIL_STRB_W-1:0] wstrb_i,
  output logic                   bvalid_o,
  input  logic                   bready_i,
  output logic [1:0]             bresp_o,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  input  logic [AXIL_ADDR_W-1:0] araddr_i,
  input  logic                   arprot_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [AXIL_DATA_W-1:0] rdata_o,
  output logic [1:0]             rresp_o
);

  localparam int                     IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]             LAT_M1  = 4'(RD_LAT - 1);
  localparam logic [AXIL_ADDR_W-1:0] WORDS64 = AXIL_ADDR_W'(MEM_WORDS);

  logic w_unused_prot;
  assign w_unused_prot = awprot_i ^ arprot_i;

  // ---------------------------------------------------------------- write
  logic                   r_aw_held;
  logic [AXIL_ADDR_W-1:0] r_aw_addr;
  logic                   r_w_held;
  logic [AXIL_DATA_W-1:0] r_w_data;
  logic [AXIL_STRB_W-1:0] r_w_strb;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;

  logic                   w_aw_fire, w_w_fire, w_commit, w_wr_err, w_mem_we;
  logic [AXIL_ADDR_W-1:0] w_wr_addr;
  logic [AXIL_DATA_W-1:0] w_wr_data;
  logic [AXIL_STRB_W-1:0] w_wr_strb;
  logic [IDX_W-1:0]       w_wr_idx;

  assign awready_o = !r_aw_held && !r_bvalid;
  assign wready_o  = !r_w_held  && !r_bvalid;
  assign w_aw_fire = awvalid_i && awready_o;
  assign w_w_fire  = wvalid_i  && wready_o;

  // A half arriving this cycle counts as available, so the commit lands in
  // the cycle the second half is accepted and B follows one cycle later.
  assign w_commit  = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire) && !r_bvalid;
  assign w_wr_addr = r_aw_held ? r_aw_addr : awaddr_i;
  assign w_wr_data = r_w_held  ? r_w_data  : wdata_i;
  assign w_wr_strb = r_w_held  ? r_w_strb  : wstrb_i;
  assign w_wr_err  = addr_bad(w_wr_addr, BASE_ADDR, WORDS64);
  assign w_wr_idx  = IDX_W'((w_wr_addr - BASE_ADDR) >> 3);
  assign w_mem_we  = w_commit && !w_wr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= awaddr_i;
      end
      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_w_data <= wdata_i;
        r_w_strb <= wstrb_i;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && bready_i) begin
        r_bvalid  <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign bvalid_o = r_bvalid;
  assign bresp_o  = r_bresp;

  // ----------------------------------------------------------------- read
  rd_state_e              r_rstate;
  logic [3:0]             r_cnt;
  logic [AXIL_ADDR_W-1:0] r_ar_addr;
  logic                   r_rvalid;
  logic [1:0]             r_rresp;

  logic                   w_ar_fire, w_rd_sample, w_rd_err, w_mem_re;
  logic [1:0]             w_rd_resp;
  logic [AXIL_ADDR_W-1:0] w_rd_addr;
  logic [IDX_W-1:0]       w_rd_idx;
  logic [AXIL_DATA_W-1:0] w_mem_rdata;

  assign arready_o = (r_rstate == R_IDLE);
  assign w_ar_fire = arvalid_i && arready_o;
  assign w_rd_addr = (r_rstate == R_IDLE) ? araddr_i : r_ar_addr;
  assign w_rd_err  = addr_bad(w_rd_addr, BASE_ADDR, WORDS64);
  assign w_rd_resp = w_rd_err ? RESP_SLVERR : RESP_OKAY;
  assign w_rd_idx  = IDX_W'((w_rd_addr - BASE_ADDR) >> 3);

  // The storage read is issued on the edge that enters R_RESP, so its
  // registered output is valid together with rvalid_o.
  assign w_rd_sample = (w_ar_fire && (RD_LAT == 1)) ||
                       ((r_rstate == R_WAIT) && (r_cnt == 4'd1));
  assign w_mem_re    = w_rd_sample && !w_rd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_cnt     <= '0;
      r_ar_addr <= '0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid_i) begin
            r_ar_addr <= araddr_i;
            r_cnt     <= LAT_M1;
            if (RD_LAT == 1) begin
              r_rstate <= R_RESP;
              r_rvalid <= 1'b1;
              r_rresp  <= w_rd_resp;
            end else begin
              r_rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rstate <= R_RESP;
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
          end
        end
        R_RESP: begin
          if (rready_i) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign rvalid_o = r_rvalid;
  assign rresp_o  = r_rresp;
  // Error responses carry zero data; the array output is only meaningful
  // while an OKAY response is being presented.
  assign rdata_o  = (r_rvalid && (r_rresp == RESP_OKAY)) ? w_mem_rdata : '0;

  axil_sram_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_wr_idx),
    .i_wdata (w_wr_data),
    .i_wstrb (w_wr_strb),
    .i_re    (w_mem_re),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

endmodule
